axi_mem_slave: RTL

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_if.sv | 66 ++++++
 rtl/be_dp_ram.sv | 36 +++
 rtl/axi_mem_slave.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI response codes and FSM state encodings for the memory responder.
package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_if.sv
// AXI bundle (aw/w/b/ar/r) with len, user, strb, last and resp; widths travel with the instance.
interface axi_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [STROBE_WIDTH-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awlen, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bresp, buser, bvalid,
    input  bready,
    input  araddr, arlen, aruser, arvalid,
    output arready,
    output rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bresp, buser, bvalid,
    output bready,
    output araddr, arlen, aruser, arvalid,
    input  arready,
    input  rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

endinterface

// File: rtl/be_dp_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port, no reset on contents.
module be_dp_ram #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_BITS-1:0]    waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [ADDR_BITS-1:0]    raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;

  // One array per byte lane keeps each lane a plain single-write-port memory.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i] <= wdata_i[b*8 +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o[b*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI memory responder: independent INCR-burst write and read FSMs over a byte-enable RAM.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input logic  clk,
  input logic  rst,
  axi_if.slave s_axi
);

  localparam int AW     = s_axi.ADDR_WIDTH;
  localparam int DW     = s_axi.DATA_WIDTH;
  localparam int SW     = s_axi.STROBE_WIDTH;
  localparam int OFF    = $clog2(SW);
  localparam int IDX_HI = OFF + MEM_DEPTH_LOG2;
  localparam logic [AW-1:0] STEP = AW'(SW);

  wr_state_e           w_state_q;
  logic [AW-1:0]       w_addr_q;
  logic [7:0]          w_len_q;
  logic [7:0]          w_beat_q;
  logic                w_decerr_q;
  logic                w_slverr_q;

  rd_state_e           r_state_q;
  logic [AW-1:0]       r_addr_q;
  logic [7:0]          r_len_q;
  logic [7:0]          r_beat_q;
  logic [1:0]          r_resp_q;
  logic                r_last_q;

  logic                w_in_range;
  logic                r_in_range;
  logic                ram_we;
  logic                ram_re;
  logic [DW-1:0]       ram_rdata;

  assign w_in_range = (w_addr_q >> IDX_HI) == '0;
  assign r_in_range = (r_addr_q >> IDX_HI) == '0;
  assign ram_we     = (w_state_q == W_DATA) && s_axi.wvalid && w_in_range && !rst;
  assign ram_re     = (r_state_q == R_FETCH) && !rst;

  be_dp_ram #(
    .ADDR_BITS (MEM_DEPTH_LOG2),
    .DATA_WIDTH(DW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .be_i   (s_axi.wstrb),
    .waddr_i(w_addr_q[IDX_HI-1:OFF]),
    .wdata_i(s_axi.wdata),
    .re_i   (ram_re),
    .raddr_i(r_addr_q[IDX_HI-1:OFF]),
    .rdata_o(ram_rdata)
  );

  // Handshake outputs are gated by rst so they read 0 throughout reset.
  assign s_axi.awready = (w_state_q == W_IDLE) && !rst;
  assign s_axi.wready  = (w_state_q == W_DATA) && !rst;
  assign s_axi.bvalid  = (w_state_q == W_RESP) && !rst;
  assign s_axi.bresp   = w_decerr_q ? DECERR : (w_slverr_q ? SLVERR : OKAY);
  assign s_axi.buser   = '0;

  assign s_axi.arready = (r_state_q == R_IDLE) && !rst;
  assign s_axi.rvalid  = (r_state_q == R_DATA) && !rst;
  assign s_axi.rdata   = (r_resp_q == DECERR) ? '0 : ram_rdata;
  assign s_axi.rresp   = r_resp_q;
  assign s_axi.rlast   = r_last_q;
  assign s_axi.ruser   = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_beat_q   <= '0;
      w_decerr_q <= 1'b0;
      w_slverr_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s_axi.awvalid) begin
            w_addr_q   <= s_axi.awaddr;
            w_len_q    <= s_axi.awlen;
            w_beat_q   <= '0;
            w_decerr_q <= 1'b0;
            w_slverr_q <= 1'b0;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid) begin
            if (!w_in_range) begin
              w_decerr_q <= 1'b1;
            end
            if (s_axi.wlast != (w_beat_q == w_len_q)) begin
              w_slverr_q <= 1'b1;
            end
            w_addr_q <= w_addr_q + STEP;
            w_beat_q <= w_beat_q + 8'd1;
            // Burst length comes from awlen alone; wlast only feeds the error flag.
            if (w_beat_q == w_len_q) begin
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_resp_q  <= OKAY;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi.arvalid) begin
            r_addr_q  <= s_axi.araddr;
            r_len_q   <= s_axi.arlen;
            r_beat_q  <= '0;
            r_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_resp_q  <= r_in_range ? OKAY : DECERR;
          r_last_q  <= (r_beat_q == r_len_q);
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (s_axi.rready) begin
            if (r_last_q) begin
              r_state_q <= R_IDLE;
            end else begin
              r_addr_q  <= r_addr_q + STEP;
              r_beat_q  <= r_beat_q + 8'd1;
              r_state_q <= R_FETCH;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.awuser, s_axi.wuser, s_axi.aruser,
                       w_addr_q[OFF-1:0], r_addr_q[OFF-1:0]};

endmodule
